// File: rtl/stopwatch_display.sv
// stopwatch_display: freezable MM.SS.HH snapshot, serial double-dabble BCD conversion and
// six-digit active-low 7-segment scan. Optional build macro: LEADING_ZERO_BLANK_EN.
module stopwatch_display #(
    parameter int FREQUENCY = 100_000_000,
    parameter int SCAN_HZ   = 1000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [3:0] minutes,
    input  logic [5:0] seconds,
    input  logic [6:0] hundredths,
    input  logic       freeze_in,
    output logic [6:0] cat_out,
    output logic       dp_out,
    output logic [5:0] an_out,
    output logic       busy_out
);
    localparam int DIG_CYC = FREQUENCY / SCAN_HZ;
    localparam int DW = $clog2(DIG_CYC);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIG_CYC - 1);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
    state_t r_state, w_state_next;

    logic [DW-1:0] r_dwell;
    logic [2:0]    r_idx;
    logic [20:0]   r_snap;
    logic [4:0]    r_bit;
    logic [7:0]    r_acc;
    logic [7:0]    r_bcd_h, r_bcd_s, r_bcd_m;
    logic [3:0]    r_dig [6];
    logic [6:0]    r_cat;
    logic          r_dp;
    logic [5:0]    r_an;
    logic          r_busy;

    logic       w_wrap, w_tick, w_capture;
    logic [6:0] w_hun_sat;
    logic [7:0] w_acc_adj, w_acc_shift;
    logic [3:0] w_cur;
    logic [6:0] w_cat_next;

    assign w_wrap    = (r_dwell == DWELL_LAST);
    assign w_tick    = w_wrap && (r_idx == 3'd5);
    assign w_capture = w_tick && !freeze_in && (r_state == IDLE);
    assign w_hun_sat = (hundredths > 7'd99) ? 7'd99 : hundredths;

    // Add-3 on each nibble >= 5, then shift in the next snapshot bit.
    always_comb begin
        w_acc_adj = r_acc;
        if (r_acc[3:0] >= 4'd5) w_acc_adj[3:0] = r_acc[3:0] + 4'd3;
        if (r_acc[7:4] >= 4'd5) w_acc_adj[7:4] = r_acc[7:4] + 4'd3;
        w_acc_shift = (w_acc_adj << 1) | {7'b0, r_snap[20]};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_dwell <= '0;
            r_idx   <= 3'd0;
        end else if (w_wrap) begin
            r_dwell <= '0;
            r_idx   <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_capture) w_state_next = CONV;
            CONV:    if (r_bit == 5'd20) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Snapshot layout {hundredths, seconds, minutes}, 7 bits per field, shifted out MSB-first.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_snap  <= '0;
            r_bit   <= '0;
            r_acc   <= '0;
            r_bcd_h <= '0;
            r_bcd_s <= '0;
            r_bcd_m <= '0;
            for (int i = 0; i < 6; i++) r_dig[i] <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_capture) begin
                    r_snap <= {w_hun_sat, 1'b0, seconds, 3'b000, minutes};
                    r_bit  <= '0;
                    r_acc  <= '0;
                end
                CONV: begin
                    r_snap <= {r_snap[19:0], 1'b0};
                    r_bit  <= r_bit + 5'd1;
                    case (r_bit)
                        5'd6:    begin r_bcd_h <= w_acc_shift; r_acc <= '0; end
                        5'd13:   begin r_bcd_s <= w_acc_shift; r_acc <= '0; end
                        5'd20:   begin r_bcd_m <= w_acc_shift; r_acc <= '0; end
                        default: r_acc <= w_acc_shift;
                    endcase
                end
                COMMIT: begin
                    r_dig[0] <= r_bcd_h[3:0];
                    r_dig[1] <= r_bcd_h[7:4];
                    r_dig[2] <= r_bcd_s[3:0];
                    r_dig[3] <= r_bcd_s[7:4];
                    r_dig[4] <= r_bcd_m[3:0];
                    r_dig[5] <= r_bcd_m[7:4];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_idx)
            3'd0:    w_cur = r_dig[0];
            3'd1:    w_cur = r_dig[1];
            3'd2:    w_cur = r_dig[2];
            3'd3:    w_cur = r_dig[3];
            3'd4:    w_cur = r_dig[4];
            3'd5:    w_cur = r_dig[5];
            default: w_cur = 4'd0;
        endcase
    end

    always_comb begin
        case (w_cur)
            4'd0:    w_cat_next = 7'b1000000;
            4'd1:    w_cat_next = 7'b1111001;
            4'd2:    w_cat_next = 7'b0100100;
            4'd3:    w_cat_next = 7'b0110000;
            4'd4:    w_cat_next = 7'b0011001;
            4'd5:    w_cat_next = 7'b0010010;
            4'd6:    w_cat_next = 7'b0000010;
            4'd7:    w_cat_next = 7'b1111000;
            4'd8:    w_cat_next = 7'b0000000;
            4'd9:    w_cat_next = 7'b0010000;
            default: w_cat_next = 7'h7F;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (r_idx == 3'd5 && r_dig[5] == 4'd0) w_cat_next = 7'h7F;
`endif
    end

    // busy covers the capture cycle through the commit cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cat  <= 7'h7F;
            r_dp   <= 1'b1;
            r_an   <= 6'h3F;
            r_busy <= 1'b0;
        end else begin
            r_cat  <= w_cat_next;
            r_dp   <= !((r_idx == 3'd2) || (r_idx == 3'd4));
            r_an   <= ~(6'b1 << r_idx);
            r_busy <= w_capture || (r_state != IDLE);
        end
    end

    assign cat_out  = r_cat;
    assign dp_out   = r_dp;
    assign an_out   = r_an;
    assign busy_out = r_busy;
endmodule
